// File: rtl/predictor_pkg.sv
// Shared definitions for the branch predictor table and its arbiter.
//   PRED_IDX_W   table index width (ENTRIES = 2**PRED_IDX_W)
//   CTR_RESET    power-on value of every 2-bit counter (weakly not-taken)
//   upd_entry_t  one queued resolve outcome {idx, taken}
//   sat_inc/dec  saturating 2-bit counter arithmetic
package predictor_pkg;

  localparam int         PRED_IDX_W = 4;
  localparam logic [1:0] CTR_RESET  = 2'b01;

  typedef struct packed {
    logic [PRED_IDX_W-1:0] idx;
    logic                  taken;
  } upd_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == 2'b11) ? ctr : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/predictor_arbiter_if.sv
// Fetch-lookup and execute-resolve signals of the predictor arbiter.
//   slave  : the arbiter side (consumes request/result, drives ack/prediction)
//   master : the fetch/execute side
//   request/lookup_idx -> lookup_ack (comb), prediction/pred_valid (registered)
//   result/update_idx/taken -> update_ready (comb), queue_count
interface predictor_arbiter_if
  import predictor_pkg::*;
#(
  parameter int IDX_W      = PRED_IDX_W,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             request;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ack;
  logic             prediction;
  logic             pred_valid;
  logic             result;
  logic [IDX_W-1:0] update_idx;
  logic             taken;
  logic             update_ready;
  logic [CNT_W-1:0] queue_count;

  modport slave (
    input  request, lookup_idx, result, update_idx, taken,
    output lookup_ack, prediction, pred_valid, update_ready, queue_count
  );

  modport master (
    output request, lookup_idx, result, update_idx, taken,
    input  lookup_ack, prediction, pred_valid, update_ready, queue_count
  );

endinterface

// File: rtl/predictor_update_fifo.sv
// Small circular queue holding resolved-branch outcomes until the table is free.
//   clk, rst_n  clock / async active-low reset (pointers and count only)
//   push_i      enqueue wdata_i (caller guarantees !full_o)
//   pop_i       dequeue head_o (caller guarantees !empty_o)
//   head_o      oldest entry
//   full_o, empty_o, count_o  occupancy
module predictor_update_fifo
  import predictor_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  upd_entry_t       wdata_i,
  output upd_entry_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  upd_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/predictor_arbiter.sv
// Table of 2-bit saturating branch counters shared between a fetch lookup
// port and an execute resolve port. One table operation per cycle: lookups
// win unless the update queue is full or has been starved for STARVE_MAX
// consecutive lookups, or there is no lookup pending.
//   clk, rst_n  clock / async active-low reset
//   bus         predictor_arbiter_if.slave (lookup and resolve handshakes)
module predictor_arbiter
  import predictor_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  predictor_arbiter_if.slave bus
);

  localparam int IDX_W   = PRED_IDX_W;
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int SW      = $clog2(STARVE_MAX + 1);

  logic [1:0]       table_q [ENTRIES];
  logic [SW-1:0]    starve_q, starve_d;
  logic             prediction_q, prediction_d;
  logic             pred_valid_q, pred_valid_d;

  logic             fifo_full, fifo_empty, fifo_push;
  logic [CNT_W-1:0] fifo_count;
  upd_entry_t       fifo_head, fifo_wdata;
  logic             drain, ack;
  logic [1:0]       ctr_next;

  assign fifo_push  = bus.result && !fifo_full;
  assign fifo_wdata = '{idx: bus.update_idx, taken: bus.taken};

  predictor_update_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (drain),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Arbitration: a drain preempts the lookup when updates are pending and
  // either nobody is looking up, the queue is full, or it has been starved.
  always_comb begin
    drain = !fifo_empty &&
            (!bus.request || fifo_full || (starve_q == SW'(STARVE_MAX)));
    ack   = bus.request && !drain;
  end

  // Starve counter only measures lookups that bypassed a non-empty queue.
  always_comb begin
    starve_d = starve_q;
    if (drain || fifo_empty)
      starve_d = '0;
    else if (ack && (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + SW'(1);
  end

  // Lookup reads architectural table state; queued updates are not forwarded.
  always_comb begin
    prediction_d = ack ? table_q[bus.lookup_idx][1] : prediction_q;
    pred_valid_d = ack;
    ctr_next     = fifo_head.taken ? sat_inc(table_q[fifo_head.idx])
                                   : sat_dec(table_q[fifo_head.idx]);
  end

  // ---- stage boundary: table write, starve counter, prediction output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
      starve_q     <= '0;
      prediction_q <= 1'b0;
      pred_valid_q <= 1'b0;
    end else begin
      if (drain) table_q[fifo_head.idx] <= ctr_next;
      starve_q     <= starve_d;
      prediction_q <= prediction_d;
      pred_valid_q <= pred_valid_d;
    end
  end

  assign bus.lookup_ack   = ack;
  assign bus.prediction   = prediction_q;
  assign bus.pred_valid   = pred_valid_q;
  assign bus.update_ready = !fifo_full;
  assign bus.queue_count  = fifo_count;

endmodule

// File: tb/tb_predictor_arbiter.sv
module tb_predictor_arbiter;
  import predictor_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   sb [$];

  predictor_arbiter_if #(.IDX_W(PRED_IDX_W), .FIFO_DEPTH(4)) bus ();

  predictor_arbiter #(
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every prediction pulse must match the oldest expected prediction.
  always @(negedge clk) begin
    if (rst_n && bus.pred_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pred_valid: got pulse, expected none");
      end else begin
        check("prediction", int'(bus.prediction), int'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.request = 1'b0;
    bus.result  = 1'b0;
    repeat (n) step();
  endtask

  // Single lookup with an empty queue: must be acked, prediction 1 cycle later.
  task automatic lookup(input int idx, input bit exp);
    logic [PRED_IDX_W-1:0] i4;
    i4 = PRED_IDX_W'(idx);
    bus.request    = 1'b1;
    bus.lookup_idx = i4;
    #1;
    check($sformatf("lookup_ack_idx%0d", idx), int'(bus.lookup_ack), 1);
    sb.push_back(exp);
    step();
    bus.request = 1'b0;
  endtask

  task automatic push_upd(input int idx, input bit t);
    logic [PRED_IDX_W-1:0] i4;
    i4 = PRED_IDX_W'(idx);
    bus.result     = 1'b1;
    bus.update_idx = i4;
    bus.taken      = t;
    #1;
    check($sformatf("update_ready_idx%0d", idx), int'(bus.update_ready), 1);
    step();
    bus.result = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.request    = 1'b0;
    bus.lookup_idx = '0;
    bus.result     = 1'b0;
    bus.update_idx = '0;
    bus.taken      = 1'b0;
    repeat (2) step();

    // 1: reset state and first lookup
    check("rst_pred_valid",   int'(bus.pred_valid),   0);
    check("rst_prediction",   int'(bus.prediction),   0);
    check("rst_queue_count",  int'(bus.queue_count),  0);
    check("rst_update_ready", int'(bus.update_ready), 1);
    check("rst_lookup_ack",   int'(bus.lookup_ack),   0);
    rst_n = 1'b1;
    step();
    lookup(3, 1'b0);
    idle(2);

    // 2: two taken on idx 5 -> 11; four more stay 11; one not-taken -> 10
    push_upd(5, 1'b1);
    push_upd(5, 1'b1);
    idle(3);
    lookup(5, 1'b1);
    for (int k = 0; k < 4; k++) push_upd(5, 1'b1);
    idle(6);
    push_upd(5, 1'b0);
    idle(3);
    lookup(5, 1'b1);
    idle(2);

    // 5: not-taken x3 on idx 0 -> 00; one taken -> 01, still predicts 0
    for (int k = 0; k < 3; k++) push_upd(0, 1'b0);
    idle(4);
    lookup(0, 1'b0);
    push_upd(0, 1'b1);
    idle(3);
    lookup(0, 1'b0);
    idle(2);

    // 3: request held; one update pushed in cycle 0 drains in cycle 9
    bus.request    = 1'b1;
    bus.lookup_idx = 4'd7;
    bus.result     = 1'b1;
    bus.update_idx = 4'd9;
    bus.taken      = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      check($sformatf("starve_ack_c%0d", i), int'(bus.lookup_ack), (i != 9) ? 1 : 0);
      check($sformatf("starve_count_c%0d", i), int'(bus.queue_count),
            (i >= 1 && i <= 9) ? 1 : 0);
      if (i != 9) sb.push_back(1'b0);
      step();
      bus.result = 1'b0;
    end
    idle(2);
    lookup(9, 1'b1);
    idle(2);

    // 4: fill the queue while lookups are held
    bus.request    = 1'b1;
    bus.lookup_idx = 4'd7;
    for (int i = 0; i < 4; i++) begin
      bus.result     = 1'b1;
      bus.update_idx = (i < 2) ? 4'd10 : 4'd11;
      bus.taken      = (i < 2);
      #1;
      check($sformatf("fill_ready_%0d", i), int'(bus.update_ready), 1);
      check($sformatf("fill_ack_%0d", i),   int'(bus.lookup_ack),   1);
      check($sformatf("fill_count_%0d", i), int'(bus.queue_count),  i);
      sb.push_back(1'b0);
      step();
    end
    bus.result = 1'b0;
    #1;
    check("full_ready", int'(bus.update_ready), 0);
    check("full_ack",   int'(bus.lookup_ack),   0);
    check("full_count", int'(bus.queue_count),  4);
    step();
    bus.request    = 1'b0;
    bus.result     = 1'b1;
    bus.update_idx = 4'd12;
    bus.taken      = 1'b1;
    #1;
    check("pushpop_ready",     int'(bus.update_ready), 1);
    check("pushpop_count_pre", int'(bus.queue_count),  3);
    step();
    bus.result = 1'b0;
    #1;
    check("pushpop_count_post", int'(bus.queue_count), 3);
    idle(6);
    check("drained_count", int'(bus.queue_count), 0);
    lookup(10, 1'b1);
    lookup(11, 1'b0);
    lookup(12, 1'b1);
    idle(2);

    // 6: async reset with 3 queued updates and a prediction in flight
    bus.request    = 1'b1;
    bus.lookup_idx = 4'd5;
    for (int i = 0; i < 3; i++) begin
      bus.result     = 1'b1;
      bus.update_idx = 4'd14;
      bus.taken      = 1'b1;
      #1;
      check($sformatf("pre_rst_ack_%0d", i), int'(bus.lookup_ack), 1);
      sb.push_back(1'b1);
      step();
    end
    bus.result  = 1'b0;
    bus.request = 1'b0;
    #1;
    check("pre_rst_pred_valid", int'(bus.pred_valid),  1);
    check("pre_rst_prediction", int'(bus.prediction),  1);
    check("pre_rst_count",      int'(bus.queue_count), 3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_pred_valid", int'(bus.pred_valid),   0);
    check("async_rst_prediction", int'(bus.prediction),   0);
    check("async_rst_count",      int'(bus.queue_count),  0);
    check("async_rst_ready",      int'(bus.update_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    lookup(5, 1'b0);
    lookup(14, 1'b0);
    lookup(10, 1'b0);
    idle(3);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
